axi4stream_vip_buffer: RTL and testbench
========================================

Name: axi4stream_vip_buffer

Overview:
Parametrised AXI4-Stream inline block for VIP slots, the successor to the pure pass-through. It supports three modes: tie-off, combinational pass-through, and a buffered FIFO of configurable depth. It also provides beat/packet counters and sticky slave-side protocol-violation flags. It sits between a stream source and sink in the VIP wrapper and in test harnesses.

Parameters:
C_MODE, 1, 0 = tie-off (all outputs 0), 1 = combinational pass-through, 2 = FIFO buffer
C_DATA_WIDTH, 8, tdata width in bits; multiple of 8, minimum 8
C_ID_WIDTH, 0, tid width; 0 means a 1-bit port driven to 0 on the master side
C_DEST_WIDTH, 0, tdest width; 0 handled as for tid
C_USER_WIDTH, 0, tuser width; 0 handled as for tid
C_FIFO_DEPTH, 16, FIFO entries in mode 2; power of 2 in the range 2..256
C_CNT_WIDTH, 32, width of the beat and packet counters

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
aclken  in  1  clock enable; when 0 all state holds
s_axis_tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser  in/out/in...  per params (tstrb/tkeep = C_DATA_WIDTH/8)  slave stream
m_axis_tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser  out/in/out...  per params  master stream
cnt_clear  in  1  synchronous clear of counters and error flags
beat_cnt  out  C_CNT_WIDTH  master-side handshakes completed
pkt_cnt  out  C_CNT_WIDTH  master-side handshakes with tlast=1
fifo_level  out  clog2(C_FIFO_DEPTH)+1  entries held; 0 in modes 0/1
err_valid_drop  out  1  sticky: s_axis_tvalid deasserted before handshake
err_payload_change  out  1  sticky: slave payload changed while stalled

Behaviour:
- Reset (areset=1 at a clock edge with aclken=1, or when aclken=0; reset overrides aclken): FIFO emptied; read/write pointers 0; all counters, flags and fifo_level 0; m_axis_tvalid=0; in mode 2, s_axis_tready=0 during reset and =1 from the first cycle after reset.
- Mode 0: s_axis_tready=0, m_axis_* = 0 permanently. Counters stay 0. Protocol checks remain active.
- Mode 1: m_axis_* = s_axis_*, s_axis_tready = m_axis_tready, zero latency, no storage.
- Mode 2, FIFO:
  - s_axis_tready = !full, registered.
  - m_axis_tvalid = !empty.
  - m_axis payload is driven from the head entry.
  - push = s_tvalid & s_tready & aclken; pop = m_tvalid & m_tready & aclken.
  - Latency: a beat accepted at edge N is visible on m_axis after edge N. There is no empty-bypass path.
  - When full, s_axis_tready=0 even if a pop occurs that cycle; it rises the cycle after the pop.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
  - Pointers wrap modulo C_FIFO_DEPTH. fifo_level = write count minus read count.
  - Once asserted, m_axis_tvalid holds until pop, and the head payload is stable.
- Counters (all modes):
  - beat_cnt increments on each master handshake; pkt_cnt increments when tlast=1 at that handshake.
  - Both saturate at all-ones and do not wrap.
  - cnt_clear has priority over increment on the same edge.
- Protocol checks on the slave side:
  - Register stall = s_tvalid & !s_tready, plus the full slave payload.
  - If stall was 1 last cycle and s_tvalid is now 0, set err_valid_drop.
  - If stall was 1 last cycle, s_tvalid is now 1, and any payload field differs, set err_payload_change.
  - Both flags are sticky until areset or cnt_clear.
  - Checks are evaluated only on edges where aclken=1.
- aclken=0: no push, pop, counter, pointer or flag update. Outputs hold their values.
- Reset during operation: in-flight FIFO contents are discarded. m_axis_tvalid drops on the edge where reset is sampled.

Test Plan:
- Mode 2, depth 4, m_tready=0, push 5 beats (0x11..0x15) -> s_tready low after the 4th beat; fifo_level=4; beat 0x15 is held off. Raise m_tready -> output order 0x11..0x15, and s_tready returns one cycle after the first pop.
- Mode 2, continuous s_tvalid and m_tready=1 for 100 beats, tlast on every 10th -> throughput 1 beat/cycle after 1-cycle latency; beat_cnt=100, pkt_cnt=10; fifo_level stays at most 1.
- Mode 1, random backpressure -> m_axis matches s_axis every cycle, tready matches combinationally, zero latency. Mode 0 -> all outputs 0 and counters stay 0.
- Stall with s_tvalid=1 and tdata=0xA5, then change to 0x5A while still stalled -> err_payload_change=1 next cycle. Separately, drop tvalid during a stall -> err_valid_drop=1. Pulse cnt_clear -> both flags 0 and counters 0.
- C_CNT_WIDTH=4, 20 handshakes -> beat_cnt saturates at 15. Assert cnt_clear on the same edge as a handshake -> beat_cnt=0.
- Fill FIFO with 3 beats, assert areset for 1 cycle -> m_tvalid=0 and fifo_level=0. After reset, a new beat 0x77 emerges first. Then hold aclken=0 with m_tready=1 -> no pop and no level change.

Source files
------------

// File: rtl/axi4stream_vip_buffer.sv
// AXI4-Stream inline VIP slot: tie-off, pass-through or FIFO buffer,
// with master-side beat/packet counters and sticky slave protocol checks.
module axi4stream_vip_buffer #(
  parameter int unsigned C_MODE       = 1,
  parameter int unsigned C_DATA_WIDTH = 8,
  parameter int unsigned C_ID_WIDTH   = 0,
  parameter int unsigned C_DEST_WIDTH = 0,
  parameter int unsigned C_USER_WIDTH = 0,
  parameter int unsigned C_FIFO_DEPTH = 16,
  parameter int unsigned C_CNT_WIDTH  = 32
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  input  logic                                          aclken,
  input  logic                                          s_axis_tvalid,
  output logic                                          s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]                     s_axis_tstrb,
  input  logic [C_DATA_WIDTH/8-1:0]                     s_axis_tkeep,
  input  logic                                          s_axis_tlast,
  input  logic [((C_ID_WIDTH > 0) ? C_ID_WIDTH : 1)-1:0]     s_axis_tid,
  input  logic [((C_DEST_WIDTH > 0) ? C_DEST_WIDTH : 1)-1:0] s_axis_tdest,
  input  logic [((C_USER_WIDTH > 0) ? C_USER_WIDTH : 1)-1:0] s_axis_tuser,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]                       m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]                     m_axis_tstrb,
  output logic [C_DATA_WIDTH/8-1:0]                     m_axis_tkeep,
  output logic                                          m_axis_tlast,
  output logic [((C_ID_WIDTH > 0) ? C_ID_WIDTH : 1)-1:0]     m_axis_tid,
  output logic [((C_DEST_WIDTH > 0) ? C_DEST_WIDTH : 1)-1:0] m_axis_tdest,
  output logic [((C_USER_WIDTH > 0) ? C_USER_WIDTH : 1)-1:0] m_axis_tuser,
  input  logic                                          cnt_clear,
  output logic [C_CNT_WIDTH-1:0]                        beat_cnt,
  output logic [C_CNT_WIDTH-1:0]                        pkt_cnt,
  output logic [$clog2(C_FIFO_DEPTH):0]                 fifo_level,
  output logic                                          err_valid_drop,
  output logic                                          err_payload_change
);

  localparam int unsigned KW  = C_DATA_WIDTH / 8;
  localparam int unsigned IW  = (C_ID_WIDTH > 0) ? C_ID_WIDTH : 1;
  localparam int unsigned DSW = (C_DEST_WIDTH > 0) ? C_DEST_WIDTH : 1;
  localparam int unsigned UW  = (C_USER_WIDTH > 0) ? C_USER_WIDTH : 1;
  localparam int unsigned PW  = C_DATA_WIDTH + 2 * KW + 1 + IW + DSW + UW;
  localparam int unsigned AW  = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;

  // Zero-width sideband fields are forced to 0 so they never propagate.
  logic [IW-1:0]  s_tid_e;
  logic [DSW-1:0] s_tdest_e;
  logic [UW-1:0]  s_tuser_e;
  logic [PW-1:0]  s_pay;
  logic [PW-1:0]  m_pay;
  logic [PW-1:0]  head;

  assign s_tid_e   = (C_ID_WIDTH > 0)   ? s_axis_tid   : '0;
  assign s_tdest_e = (C_DEST_WIDTH > 0) ? s_axis_tdest : '0;
  assign s_tuser_e = (C_USER_WIDTH > 0) ? s_axis_tuser : '0;
  assign s_pay = {s_tuser_e, s_tdest_e, s_tid_e, s_axis_tlast,
                  s_axis_tkeep, s_axis_tstrb, s_axis_tdata};

  logic [PW-1:0] mem [C_FIFO_DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr, level, level_nxt;
  logic          s_ready_q;
  logic          push, pop, f_empty;

  assign level     = wr_ptr - rd_ptr;
  assign f_empty   = (level == '0);
  assign push      = (C_MODE == 2) && s_axis_tvalid && s_axis_tready && aclken;
  assign pop       = (C_MODE == 2) && !f_empty && m_axis_tready && aclken;
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign head      = mem[rd_ptr[AW-1:0]];

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b1;
    end else if (aclken) begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
      s_ready_q <= (level_nxt != LW'(C_FIFO_DEPTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_pay;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_pay         = '0;
    case (C_MODE)
      1: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_pay         = s_pay;
      end
      2: begin
        s_axis_tready = s_ready_q && !areset;
        m_axis_tvalid = !f_empty;
        m_pay         = head;
      end
      default: ;
    endcase
  end

  assign {m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tlast,
          m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = m_pay;
  assign fifo_level = (C_MODE == 2) ? level : '0;

  logic m_hs;
  assign m_hs = m_axis_tvalid && m_axis_tready && aclken;

  // Saturating counters; clear wins over a same-edge increment.
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (aclken) begin
      if (cnt_clear) begin
        beat_cnt <= '0;
        pkt_cnt  <= '0;
      end else if (m_hs) begin
        if (!(&beat_cnt))                 beat_cnt <= beat_cnt + C_CNT_WIDTH'(1);
        if (m_axis_tlast && !(&pkt_cnt))  pkt_cnt  <= pkt_cnt + C_CNT_WIDTH'(1);
      end
    end
  end

  logic          stall_q;
  logic [PW-1:0] pay_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_q            <= 1'b0;
      pay_q              <= '0;
      err_valid_drop     <= 1'b0;
      err_payload_change <= 1'b0;
    end else if (aclken) begin
      stall_q <= s_axis_tvalid && !s_axis_tready;
      pay_q   <= s_pay;
      if (cnt_clear) begin
        err_valid_drop     <= 1'b0;
        err_payload_change <= 1'b0;
      end else begin
        if (stall_q && !s_axis_tvalid)                  err_valid_drop     <= 1'b1;
        if (stall_q && s_axis_tvalid && (s_pay != pay_q)) err_payload_change <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4stream_vip_buffer.sv
// Bench: FIFO instance plus pass-through/tie-off/saturation instances sharing a
// random slave stream, all compared every cycle against a queue-based model.
module tb_axi4stream_vip_buffer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic areset, aclken;

  // FIFO instance: mode 2, depth 4, 8-bit data, no sideband
  logic       f_s_tvalid, f_s_tready, f_s_tstrb, f_s_tkeep, f_s_tlast;
  logic [7:0] f_s_tdata;
  logic [0:0] f_s_tid, f_s_tdest, f_s_tuser;
  logic       f_m_tvalid, f_m_tready, f_m_tstrb, f_m_tkeep, f_m_tlast;
  logic [7:0] f_m_tdata;
  logic [0:0] f_m_tid, f_m_tdest, f_m_tuser;
  logic       f_clr, f_vd, f_pc;
  logic [31:0] f_beat, f_pkt;
  logic [2:0] f_lvl;

  // Shared slave stream for the mode 1 / mode 0 / 4-bit-counter instances
  logic        g_s_tvalid, g_s_tlast, g_m_tready, g_clr;
  logic [15:0] g_s_tdata;
  logic [1:0]  g_s_tstrb, g_s_tkeep, g_s_tid;
  logic [2:0]  g_s_tdest;
  logic [3:0]  g_s_tuser;
  logic [29:0] g_pay;
  assign g_pay = {g_s_tuser, g_s_tdest, g_s_tid, g_s_tlast, g_s_tkeep, g_s_tstrb, g_s_tdata};

  logic        p_s_tready, p_m_tvalid, p_m_tlast, p_vd, p_pc;
  logic [15:0] p_m_tdata;
  logic [1:0]  p_m_tstrb, p_m_tkeep, p_m_tid;
  logic [2:0]  p_m_tdest;
  logic [3:0]  p_m_tuser;
  logic [31:0] p_beat, p_pkt;
  logic [4:0]  p_lvl;

  logic        t_s_tready, t_m_tvalid, t_m_tlast, t_vd, t_pc;
  logic [15:0] t_m_tdata;
  logic [1:0]  t_m_tstrb, t_m_tkeep, t_m_tid;
  logic [2:0]  t_m_tdest;
  logic [3:0]  t_m_tuser;
  logic [31:0] t_beat, t_pkt;
  logic [4:0]  t_lvl;

  logic        v_s_tready, v_m_tvalid, v_m_tlast, v_vd, v_pc;
  logic [15:0] v_m_tdata;
  logic [1:0]  v_m_tstrb, v_m_tkeep, v_m_tid;
  logic [2:0]  v_m_tdest;
  logic [3:0]  v_m_tuser;
  logic [3:0]  v_beat, v_pkt;
  logic [4:0]  v_lvl;

  axi4stream_vip_buffer #(.C_MODE(2), .C_DATA_WIDTH(8), .C_FIFO_DEPTH(4)) u_fifo (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .s_axis_tvalid(f_s_tvalid), .s_axis_tready(f_s_tready), .s_axis_tdata(f_s_tdata),
    .s_axis_tstrb(f_s_tstrb), .s_axis_tkeep(f_s_tkeep), .s_axis_tlast(f_s_tlast),
    .s_axis_tid(f_s_tid), .s_axis_tdest(f_s_tdest), .s_axis_tuser(f_s_tuser),
    .m_axis_tvalid(f_m_tvalid), .m_axis_tready(f_m_tready), .m_axis_tdata(f_m_tdata),
    .m_axis_tstrb(f_m_tstrb), .m_axis_tkeep(f_m_tkeep), .m_axis_tlast(f_m_tlast),
    .m_axis_tid(f_m_tid), .m_axis_tdest(f_m_tdest), .m_axis_tuser(f_m_tuser),
    .cnt_clear(f_clr), .beat_cnt(f_beat), .pkt_cnt(f_pkt), .fifo_level(f_lvl),
    .err_valid_drop(f_vd), .err_payload_change(f_pc));

  axi4stream_vip_buffer #(.C_MODE(1), .C_DATA_WIDTH(16), .C_ID_WIDTH(2), .C_DEST_WIDTH(3),
                          .C_USER_WIDTH(4)) u_pass (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .s_axis_tvalid(g_s_tvalid), .s_axis_tready(p_s_tready), .s_axis_tdata(g_s_tdata),
    .s_axis_tstrb(g_s_tstrb), .s_axis_tkeep(g_s_tkeep), .s_axis_tlast(g_s_tlast),
    .s_axis_tid(g_s_tid), .s_axis_tdest(g_s_tdest), .s_axis_tuser(g_s_tuser),
    .m_axis_tvalid(p_m_tvalid), .m_axis_tready(g_m_tready), .m_axis_tdata(p_m_tdata),
    .m_axis_tstrb(p_m_tstrb), .m_axis_tkeep(p_m_tkeep), .m_axis_tlast(p_m_tlast),
    .m_axis_tid(p_m_tid), .m_axis_tdest(p_m_tdest), .m_axis_tuser(p_m_tuser),
    .cnt_clear(g_clr), .beat_cnt(p_beat), .pkt_cnt(p_pkt), .fifo_level(p_lvl),
    .err_valid_drop(p_vd), .err_payload_change(p_pc));

  axi4stream_vip_buffer #(.C_MODE(0), .C_DATA_WIDTH(16), .C_ID_WIDTH(2), .C_DEST_WIDTH(3),
                          .C_USER_WIDTH(4)) u_tie (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .s_axis_tvalid(g_s_tvalid), .s_axis_tready(t_s_tready), .s_axis_tdata(g_s_tdata),
    .s_axis_tstrb(g_s_tstrb), .s_axis_tkeep(g_s_tkeep), .s_axis_tlast(g_s_tlast),
    .s_axis_tid(g_s_tid), .s_axis_tdest(g_s_tdest), .s_axis_tuser(g_s_tuser),
    .m_axis_tvalid(t_m_tvalid), .m_axis_tready(g_m_tready), .m_axis_tdata(t_m_tdata),
    .m_axis_tstrb(t_m_tstrb), .m_axis_tkeep(t_m_tkeep), .m_axis_tlast(t_m_tlast),
    .m_axis_tid(t_m_tid), .m_axis_tdest(t_m_tdest), .m_axis_tuser(t_m_tuser),
    .cnt_clear(g_clr), .beat_cnt(t_beat), .pkt_cnt(t_pkt), .fifo_level(t_lvl),
    .err_valid_drop(t_vd), .err_payload_change(t_pc));

  axi4stream_vip_buffer #(.C_MODE(1), .C_DATA_WIDTH(16), .C_ID_WIDTH(2), .C_DEST_WIDTH(3),
                          .C_USER_WIDTH(4), .C_CNT_WIDTH(4)) u_sat (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .s_axis_tvalid(g_s_tvalid), .s_axis_tready(v_s_tready), .s_axis_tdata(g_s_tdata),
    .s_axis_tstrb(g_s_tstrb), .s_axis_tkeep(g_s_tkeep), .s_axis_tlast(g_s_tlast),
    .s_axis_tid(g_s_tid), .s_axis_tdest(g_s_tdest), .s_axis_tuser(g_s_tuser),
    .m_axis_tvalid(v_m_tvalid), .m_axis_tready(g_m_tready), .m_axis_tdata(v_m_tdata),
    .m_axis_tstrb(v_m_tstrb), .m_axis_tkeep(v_m_tkeep), .m_axis_tlast(v_m_tlast),
    .m_axis_tid(v_m_tid), .m_axis_tdest(v_m_tdest), .m_axis_tuser(v_m_tuser),
    .cnt_clear(g_clr), .beat_cnt(v_beat), .pkt_cnt(v_pkt), .fifo_level(v_lvl),
    .err_valid_drop(v_vd), .err_payload_change(v_pc));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [10:0] fq[$];
  int          fb = 0, fp = 0, gb = 0, gp = 0, vb = 0, vp = 0;
  logic        fvd = 0, fpc = 0, f_pst = 0;
  logic [10:0] f_ppay = '0;
  logic        pvd = 0, ppc = 0, p_pst = 0, tvd = 0, tpc = 0, t_pst = 0;
  logic [29:0] g_ppay = '0;
  logic        f_pushed;
  int          cyc_cnt = 0;
  int          f_lvl_max = 0;

  // One clock: check outputs at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    logic f_tr, f_push, f_pop, g_hs;
    logic [10:0] f_pay;
    @(negedge aclk);
    f_tr  = !areset && (fq.size() < 4);
    f_pay = {f_s_tlast, f_s_tkeep, f_s_tstrb, f_s_tdata};
    if (int'(f_lvl) > f_lvl_max) f_lvl_max = int'(f_lvl);
    chk("f_s_tready", f_s_tready, f_tr);
    chk("f_m_tvalid", f_m_tvalid, fq.size() != 0);
    if (fq.size() != 0) chk("f_m_payload", {f_m_tlast, f_m_tkeep, f_m_tstrb, f_m_tdata}, fq[0]);
    chk("f_m_sideband", {f_m_tid, f_m_tdest, f_m_tuser}, 0);
    chk("f_level", f_lvl, fq.size());
    chk("f_beat", f_beat, fb);
    chk("f_pkt", f_pkt, fp);
    chk("f_errs", {f_vd, f_pc}, {fvd, fpc});
    chk("p_m_tvalid", p_m_tvalid, g_s_tvalid);
    chk("p_m_payload", {p_m_tuser, p_m_tdest, p_m_tid, p_m_tlast, p_m_tkeep, p_m_tstrb, p_m_tdata}, g_pay);
    chk("p_s_tready", p_s_tready, g_m_tready);
    chk("p_cnts", {p_beat, p_pkt}, {32'(gb), 32'(gp)});
    chk("p_errs", {p_vd, p_pc}, {pvd, ppc});
    chk("p_level", p_lvl, 0);
    chk("t_outs", {t_s_tready, t_m_tvalid, t_m_tuser, t_m_tdest, t_m_tid, t_m_tlast,
                   t_m_tkeep, t_m_tstrb, t_m_tdata, t_lvl}, 0);
    chk("t_cnts", {t_beat, t_pkt}, 0);
    chk("t_errs", {t_vd, t_pc}, {tvd, tpc});
    chk("v_pass", {v_s_tready, v_m_tvalid, v_m_tuser, v_m_tdest, v_m_tid, v_m_tlast,
                   v_m_tkeep, v_m_tstrb, v_m_tdata}, {g_m_tready, g_s_tvalid, g_pay});
    chk("v_cnts", {v_beat, v_pkt, v_lvl}, {4'(vb), 4'(vp), 5'd0});
    chk("v_errs", {v_vd, v_pc}, {pvd, ppc});
    f_push = f_s_tvalid && f_tr && aclken;
    f_pop  = (fq.size() != 0) && f_m_tready && aclken;
    g_hs   = g_s_tvalid && g_m_tready && aclken;
    @(posedge aclk);
    cyc_cnt++;
    f_pushed = 1'b0;
    if (areset) begin
      fq.delete();
      fb = 0; fp = 0; gb = 0; gp = 0; vb = 0; vp = 0;
      fvd = 0; fpc = 0; f_pst = 0; f_ppay = '0;
      pvd = 0; ppc = 0; p_pst = 0; tvd = 0; tpc = 0; t_pst = 0; g_ppay = '0;
    end else if (aclken) begin
      if (f_clr) begin
        fvd = 0; fpc = 0; fb = 0; fp = 0;
      end else begin
        if (f_pst && !f_s_tvalid) fvd = 1;
        if (f_pst && f_s_tvalid && f_pay != f_ppay) fpc = 1;
        if (f_pop) begin
          fb = fb + 1;
          if (fq[0][10]) fp = fp + 1;
        end
      end
      if (g_clr) begin
        pvd = 0; ppc = 0; tvd = 0; tpc = 0; gb = 0; gp = 0; vb = 0; vp = 0;
      end else begin
        if (p_pst && !g_s_tvalid) pvd = 1;
        if (p_pst && g_s_tvalid && g_pay != g_ppay) ppc = 1;
        if (t_pst && !g_s_tvalid) tvd = 1;
        if (t_pst && g_s_tvalid && g_pay != g_ppay) tpc = 1;
        if (g_hs) begin
          gb = gb + 1;
          if (vb < 15) vb = vb + 1;
          if (g_s_tlast) begin
            gp = gp + 1;
            if (vp < 15) vp = vp + 1;
          end
        end
      end
      f_pst = f_s_tvalid && !f_tr;  f_ppay = f_pay;
      p_pst = g_s_tvalid && !g_m_tready;  t_pst = g_s_tvalid;  g_ppay = g_pay;
      if (f_pop) void'(fq.pop_front());
      if (f_push) begin
        fq.push_back(f_pay);
        f_pushed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send_f();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!f_pushed && n < 20);
    if (!f_pushed) chk("f_push_timeout", f_pushed, 1);
  endtask

  initial begin
    int start;
    areset = 1; aclken = 1;
    f_s_tvalid = 0; f_s_tdata = 0; f_s_tstrb = 1; f_s_tkeep = 1; f_s_tlast = 0;
    f_s_tid = 0; f_s_tdest = 0; f_s_tuser = 0; f_m_tready = 0; f_clr = 0;
    g_s_tvalid = 0; g_s_tdata = 0; g_s_tstrb = 0; g_s_tkeep = 0; g_s_tlast = 0;
    g_s_tid = 0; g_s_tdest = 0; g_s_tuser = 0; g_m_tready = 0; g_clr = 0;

    repeat (2) cycle();
    chk("rst_level", f_lvl, 0);
    chk("rst_m_tvalid", f_m_tvalid, 0);
    chk("rst_s_tready", f_s_tready, 0);
    chk("rst_cnts", {f_beat, f_pkt, p_beat, v_beat}, 0);
    areset = 0;
    #1 chk("post_rst_s_tready", f_s_tready, 1);

    // FIFO fill to full with a held-off fifth beat, then drain in order
    for (int i = 0; i < 4; i++) begin
      f_s_tvalid = 1; f_s_tdata = 8'(8'h11 + i); f_s_tlast = 0;
      send_f();
    end
    f_s_tdata = 8'h15; f_s_tlast = 1;
    repeat (3) cycle();
    chk("full_s_tready", f_s_tready, 0);
    chk("full_level", f_lvl, 4);
    chk("full_head", f_m_tdata, 8'h11);
    f_m_tready = 1;
    cycle();
    chk("ready_after_pop", f_s_tready, 1);
    chk("level_after_pop", f_lvl, 3);
    send_f();
    f_s_tvalid = 0;
    for (int i = 0; i < 20 && fq.size() != 0; i++) cycle();
    chk("drain_level", f_lvl, 0);
    chk("drain_cnts", {f_beat, f_pkt}, {32'd5, 32'd1});

    // Streaming at full rate
    f_clr = 1; cycle(); f_clr = 0;
    f_lvl_max = 0;
    start = cyc_cnt;
    for (int i = 0; i < 100; i++) begin
      f_s_tvalid = 1; f_s_tdata = 8'(i); f_s_tlast = ((i % 10) == 9);
      send_f();
    end
    chk("stream_cycles", 64'(cyc_cnt - start), 100);
    f_s_tvalid = 0;
    cycle();
    chk("stream_beats", f_beat, 100);
    chk("stream_pkts", f_pkt, 10);
    chk("stream_level_max", 64'(f_lvl_max), 1);

    // Random pass-through / tie-off traffic with occasional clock-enable gaps
    for (int i = 0; i < 200; i++) begin
      g_s_tvalid = 1'($urandom); g_s_tdata = 16'($urandom); g_s_tstrb = 2'($urandom);
      g_s_tkeep = 2'($urandom); g_s_tlast = 1'($urandom); g_s_tid = 2'($urandom);
      g_s_tdest = 3'($urandom); g_s_tuser = 4'($urandom); g_m_tready = 1'($urandom);
      aclken = ($urandom_range(0, 9) != 0);
      cycle();
    end
    aclken = 1;

    // Protocol checks
    g_s_tvalid = 0; g_m_tready = 1; g_s_tdata = 0; g_s_tstrb = 0; g_s_tkeep = 0;
    g_s_tlast = 0; g_s_tid = 0; g_s_tdest = 0; g_s_tuser = 0;
    g_clr = 1; cycle(); g_clr = 0;
    chk("clr_errs", {p_vd, p_pc}, 0);
    g_m_tready = 0; g_s_tvalid = 1; g_s_tdata = 16'h00A5;
    repeat (2) cycle();
    g_s_tdata = 16'h005A;
    cycle();
    chk("payload_change", {p_vd, p_pc}, 2'b01);
    g_clr = 1; cycle(); g_clr = 0;
    cycle();
    g_s_tvalid = 0;
    cycle();
    chk("valid_drop", {p_vd, p_pc}, 2'b10);
    g_clr = 1; cycle(); g_clr = 0;
    chk("clr_all", {p_vd, p_pc, p_beat, p_pkt}, 0);

    // Saturation at 4 bits, and clear beating a same-edge handshake
    g_s_tvalid = 1; g_m_tready = 1;
    repeat (20) cycle();
    chk("sat_beat", v_beat, 15);
    chk("nosat_beat", p_beat, 20);
    g_clr = 1; cycle(); g_clr = 0;
    chk("clr_prio", {v_beat, p_beat}, 0);
    g_s_tvalid = 0;

    // Reset discards in-flight beats; clock enable freezes the FIFO
    f_m_tready = 0;
    for (int i = 0; i < 3; i++) begin
      f_s_tvalid = 1; f_s_tdata = 8'(8'h31 + i); f_s_tlast = 0;
      send_f();
    end
    f_s_tvalid = 0;
    chk("pre_rst_level", f_lvl, 3);
    areset = 1; cycle(); areset = 0;
    chk("mid_rst_m_tvalid", f_m_tvalid, 0);
    chk("mid_rst_level", f_lvl, 0);
    f_s_tvalid = 1; f_s_tdata = 8'h77;
    send_f();
    f_s_tvalid = 0;
    cycle();
    chk("new_head", {f_m_tvalid, f_m_tdata}, {1'b1, 8'h77});
    aclken = 0; f_m_tready = 1;
    repeat (3) cycle();
    chk("hold_level", f_lvl, 1);
    chk("hold_m_tvalid", f_m_tvalid, 1);
    aclken = 1;
    cycle();
    chk("release_level", f_lvl, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
